// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard front end: synchronizes and filters the raw lines, receives 11-bit frames,
// folds E0/F0 prefixes and presents a 16-bit scan code with make/break/error strobes.
module ps2_scan_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] answer,
  output logic        key_pressed,
  output logic        key_released,
  output logic        frame_err
);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_s;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [15:0]   answer_q, answer_d;
  logic          key_pressed_q, key_pressed_d;
  logic          key_released_q, key_released_d;

  // Glitch filter: the level follows the line only after FILTER_LEN consecutive differing samples
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall_s     = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        fall_s = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end else begin
      filt_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Frame receiver: one step per filtered falling edge; a stalled frame is aborted by timeout
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (state_q == S_IDLE || fall_s) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    if (state_q != S_IDLE && !fall_s && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end else if (fall_s) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d[bit_cnt_q] = dat_s2_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_DATA;
          end
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_s2_q && odd_parity_ok(shift_q, par_q)) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Prefix folding: E0/F0 only arm flags, E1 and any frame error drop them
  always_comb begin
    ext_d          = ext_q;
    brk_d          = brk_q;
    answer_d       = answer_q;
    key_pressed_d  = 1'b0;
    key_released_d = 1'b0;
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid_q) begin
      case (shift_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        8'hE1: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        default: begin
          answer_d       = {(ext_q ? 8'hE0 : 8'h00), shift_q};
          key_released_d = brk_q;
          key_pressed_d  = ~brk_q;
          ext_d          = 1'b0;
          brk_d          = 1'b0;
        end
      endcase
    end else begin
      answer_d = answer_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q          <= 1'b0;
      brk_q          <= 1'b0;
      answer_q       <= 16'h0000;
      key_pressed_q  <= 1'b0;
      key_released_q <= 1'b0;
    end else begin
      ext_q          <= ext_d;
      brk_q          <= brk_d;
      answer_q       <= answer_d;
      key_pressed_q  <= key_pressed_d;
      key_released_q <= key_released_d;
    end
  end

  assign answer       = answer_q;
  assign key_pressed  = key_pressed_q;
  assign key_released = key_released_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: directed vector table, multi-cycle corner
// sequences, and randomized frames scored against a prefix-folding reference model.
module tb_ps2_scan_decoder;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;
  localparam int HP         = 20;  // PS/2 half-period in clk cycles
  localparam int K_NONE = 0, K_PRESS = 1, K_REL = 2, K_ERR = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] answer;
  logic        key_pressed, key_released, frame_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_fall_cyc = 0;

  ps2_scan_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .answer(answer), .key_pressed(key_pressed), .key_released(key_released),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [15:0] ans;
    int          cyc;
  } ev_t;
  ev_t evq[$];

  // Every cycle with any strobe high is logged, so a stretched or doubled strobe shows up as extra entries
  always @(posedge clk) begin
    #1;
    if (key_pressed)  evq.push_back('{K_PRESS, answer, cyc});
    if (key_released) evq.push_back('{K_REL, answer, cyc});
    if (frame_err)    evq.push_back('{K_ERR, answer, cyc});
  end

  // Reference model: prefix flags and held answer, advanced one received frame at a time
  logic        m_ext = 1'b0, m_brk = 1'b0;
  logic [15:0] m_ans = 16'h0000;

  task automatic model_step(input logic [7:0] b, input logic good, output int kind);
    if (!good) begin
      m_ext = 1'b0; m_brk = 1'b0; kind = K_ERR;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1; kind = K_NONE;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1; kind = K_NONE;
    end else if (b == 8'hE1) begin
      m_ext = 1'b0; m_brk = 1'b0; kind = K_NONE;
    end else begin
      m_ans = {(m_ext ? 8'hE0 : 8'h00), b};
      kind  = m_brk ? K_REL : K_PRESS;
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_raw(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Strobe latency from the driven stop-bit fall: 2 synchronizer flops plus FILTER_LEN filter
  // samples put the fall-edge cycle N after posedge FILTER_LEN+1; frame_err shows in N+1, make/break in N+2.
  task automatic check_frame(input string name, input int exp_kind, input logic [15:0] exp_ans, input bit chk_lat);
    int lat, need;
    repeat (8) @(negedge clk);
    vectors++;
    if (exp_kind == K_NONE) begin
      if (evq.size() != 0) begin
        miscompares++;
        $display("FAIL %s: %0d strobe cycles seen (first kind %0d), required none", name, evq.size(), evq[0].kind);
      end
    end else if (evq.size() != 1) begin
      miscompares++;
      $display("FAIL %s: %0d strobe cycles seen, required exactly 1 of kind %0d", name, evq.size(), exp_kind);
    end else if (evq[0].kind != exp_kind || (exp_kind != K_ERR && evq[0].ans !== exp_ans)) begin
      miscompares++;
      $display("FAIL %s: strobe kind %0d answer %h, required kind %0d answer %h",
               name, evq[0].kind, evq[0].ans, exp_kind, exp_ans);
    end else if (chk_lat) begin
      lat  = evq[0].cyc - last_fall_cyc;
      need = (exp_kind == K_ERR) ? FILTER_LEN + 2 : FILTER_LEN + 3;
      if (lat != need) begin
        miscompares++;
        $display("FAIL %s latency: %0d cycles after stop edge, required %0d", name, lat, need);
      end
    end
    vectors++;
    if (answer !== exp_ans) begin
      miscompares++;
      $display("FAIL %s answer: got %h, required %h", name, answer, exp_ans);
    end
    evq.delete();
  endtask

  task automatic run_frame(input string name, input logic [7:0] b, input logic bad_par, input logic bad_stop);
    int k;
    send_raw(frame_bits(b, bad_par, bad_stop), 11);
    model_step(b, !(bad_par || bad_stop), k);
    check_frame(name, k, m_ans, 1'b1);
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        bad_par;
    logic        bad_stop;
    int          kind;
    logic [15:0] ans;
  } vec_t;
  vec_t tbl[21];

  initial begin
    int k;
    bit got;
    tbl[0]  = '{8'h1D, 1'b0, 1'b0, K_PRESS, 16'h001D};
    tbl[1]  = '{8'hE0, 1'b0, 1'b0, K_NONE,  16'h001D};
    tbl[2]  = '{8'h75, 1'b0, 1'b0, K_PRESS, 16'hE075};
    tbl[3]  = '{8'hE0, 1'b0, 1'b0, K_NONE,  16'hE075};
    tbl[4]  = '{8'hF0, 1'b0, 1'b0, K_NONE,  16'hE075};
    tbl[5]  = '{8'h72, 1'b0, 1'b0, K_REL,   16'hE072};
    tbl[6]  = '{8'h1D, 1'b0, 1'b0, K_PRESS, 16'h001D};
    tbl[7]  = '{8'h1D, 1'b1, 1'b0, K_ERR,   16'h001D};
    tbl[8]  = '{8'h1C, 1'b0, 1'b0, K_PRESS, 16'h001C};
    tbl[9]  = '{8'hF0, 1'b0, 1'b0, K_NONE,  16'h001C};
    tbl[10] = '{8'h1C, 1'b0, 1'b0, K_REL,   16'h001C};
    tbl[11] = '{8'h1C, 1'b0, 1'b0, K_PRESS, 16'h001C};
    tbl[12] = '{8'hE0, 1'b0, 1'b0, K_NONE,  16'h001C};
    tbl[13] = '{8'h5A, 1'b0, 1'b1, K_ERR,   16'h001C};
    tbl[14] = '{8'h5A, 1'b0, 1'b0, K_PRESS, 16'h005A};
    tbl[15] = '{8'hE0, 1'b0, 1'b0, K_NONE,  16'h005A};
    tbl[16] = '{8'hE1, 1'b0, 1'b0, K_NONE,  16'h005A};
    tbl[17] = '{8'h6B, 1'b0, 1'b0, K_PRESS, 16'h006B};
    tbl[18] = '{8'hF0, 1'b0, 1'b0, K_NONE,  16'h006B};
    tbl[19] = '{8'hE0, 1'b1, 1'b0, K_ERR,   16'h006B};
    tbl[20] = '{8'h6B, 1'b0, 1'b0, K_PRESS, 16'h006B};

    repeat (5) @(negedge clk);
    vectors++;
    if ({answer, key_pressed, key_released, frame_err} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_state: answer %h kp %b kr %b fe %b, required all zero",
               answer, key_pressed, key_released, frame_err);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    evq.delete();

    for (int i = 0; i < 21; i++) begin
      send_raw(frame_bits(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop), 11);
      model_step(tbl[i].b, !(tbl[i].bad_par || tbl[i].bad_stop), k);
      check_frame($sformatf("table[%0d]", i), tbl[i].kind, tbl[i].ans, 1'b1);
    end

    // Clock glitch one sample short of the filter length must leave the receiver idle
    ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk);
    check_frame("glitch", K_NONE, 16'h006B, 1'b0);
    run_frame("after_glitch", 8'h33, 1'b0, 1'b0);

    // Partial frame then silence: timeout error, and the armed E0 must be dropped
    run_frame("pre_timeout_e0", 8'hE0, 1'b0, 1'b0);
    send_raw(frame_bits(8'h29, 1'b0, 1'b0), 5);
    got = 1'b0;
    for (int c = 0; c < TIMEOUT + 200 && !got; c++) begin
      @(negedge clk);
      if (evq.size() != 0) got = 1'b1;
    end
    model_step(8'h00, 1'b0, k);
    check_frame("timeout", K_ERR, m_ans, 1'b0);
    run_frame("after_timeout", 8'h29, 1'b0, 1'b0);

    // Reset after the 4th data bit discards the frame silently
    run_frame("pre_reset_e0", 8'hE0, 1'b0, 1'b0);
    send_raw(frame_bits(8'h4B, 1'b0, 1'b0), 5);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({answer, key_pressed, key_released, frame_err} !== 19'h0) begin
      miscompares++;
      $display("FAIL midframe_reset: answer %h kp %b kr %b fe %b, required all zero",
               answer, key_pressed, key_released, frame_err);
    end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    m_ext = 1'b0; m_brk = 1'b0; m_ans = 16'h0000;
    check_frame("after_reset_quiet", K_NONE, 16'h0000, 1'b0);
    run_frame("after_reset_1D", 8'h1D, 1'b0, 1'b0);

    // Randomized frames biased toward prefixes and occasional bad frames
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      int r, e;
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hE1;
        default: b = 8'($urandom_range(0, 255));
      endcase
      e = $urandom_range(0, 9);
      run_frame($sformatf("random[%0d]=%h", i, b), b, (e == 0), (e == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Front end that turns the raw PS/2 keyboard line into the scan-code stream the game controller consumes.
- Receives PS/2 device-to-host frames and checks them.
- Folds E0 (extended) and F0 (break) prefixes into a single code.
- Presents a 16-bit code on `answer` with a one-cycle `key_pressed` strobe on make events, which is the interface the not_not answer register and judge expect.
- One instance sits between the board PS/2 pins and the game top level.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized ps2_clk samples required before the filtered clock level changes.
- TIMEOUT_CYCLES, 50000: clk cycles with no filtered falling edge inside a frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock line; asynchronous to clk.
- ps2_data  in  1  raw PS/2 data line; asynchronous to clk.
- answer  out  16  last decoded code: {8'hE0 if extended else 8'h00, code byte}.
- key_pressed  out  1  one-cycle strobe, make event; `answer` is valid in the same cycle.
- key_released  out  1  one-cycle strobe, break event; `answer` is valid in the same cycle.
- frame_err  out  1  one-cycle strobe on start, parity, stop or timeout error.

Behaviour:
- Reset values: answer=16'h0000, key_pressed=0, key_released=0, frame_err=0. Filtered clock level=1, prefix flags cleared, frame FSM in IDLE, timeout counter=0.
- Reset applied mid-frame discards the partial frame; no strobe is produced.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer (sync regs reset to 1).
  - The filtered clock level changes only after FILTER_LEN consecutive synchronized samples differ from it.
  - A fall edge is the cycle in which the filtered level goes 1->0.
  - Data is sampled from synchronized ps2_data on that cycle.
- Frame FSM, one transition per fall edge; frames are 11 bits: start(0), 8 data LSB-first, odd parity, stop(1).
  - IDLE: on fall edge, data=0 -> DATA with bit count 0; data=1 -> frame_err pulse, stay IDLE.
  - DATA: shift the sampled bit into bit[count]. After the 8th bit -> PARITY.
  - PARITY: store the sampled bit -> STOP.
  - STOP: the frame is good when data=1 and XOR(8 data bits, parity bit)=1. Good frame -> byte_valid pulse next cycle. Bad frame -> frame_err pulse. Either way -> IDLE.
- Timeout:
  - The counter runs in every state except IDLE and clears on each fall edge.
  - When it reaches TIMEOUT_CYCLES-1: frame_err pulse, FSM -> IDLE, prefix flags cleared.
- Prefix/decode stage, acting on byte_valid:
  - Byte 0xE0: set ext; no output.
  - Byte 0xF0: set brk; no output.
  - Byte 0xE1: clear both flags; no output (pause sequences unsupported).
  - Any other byte B: answer <= {ext?8'hE0:8'h00, B}. Pulse key_released if brk, else pulse key_pressed. Clear both flags.
  - Any frame_err also clears both flags.
- Latency: the fall edge of the stop bit occurs in cycle N; byte_valid is asserted in N+1; answer and strobe are asserted in N+2.
- `answer` holds its value until the next emitted code.
- Strobes are mutually exclusive and never last more than one cycle.
- Repeated make codes (typematic) each produce a key_pressed pulse.
- Filtered edges arrive at most every ~FILTER_LEN cycles, far fewer than one per decode latency, so no decode-side buffering is needed.

Test Plan:
- After reset, send frame 0x1D (good parity) -> answer=16'h001D with key_pressed high for exactly 1 cycle, 2 cycles after the stop edge; key_released=0, frame_err=0.
- Send E0 then 75 -> no strobe after E0; after 75, answer=16'hE075 and key_pressed pulses once.
- Send E0, F0, 72 -> key_released pulses once with answer=16'hE072; key_pressed never asserts; flags cleared, so a following 1D gives answer=16'h001D.
- Send 0x1D with the parity bit flipped, then a good 0x1C -> frame_err pulses once and answer stays 16'h001D; then answer=16'h001C with key_pressed.
- Send 5 bits of a frame, then idle TIMEOUT_CYCLES cycles -> frame_err pulses once; a following complete 0x29 decodes to answer=16'h0029.
- ps2_clk low glitch of FILTER_LEN-1 cycles while IDLE -> no state change, no strobes. Separately, assert reset after the 4th data bit -> outputs return to reset values with no strobe, and the next full frame decodes normally.
